// File: rtl/flow_pkg.sv
// Shared encodings and defaults for the ALU writeback / bus store-load unit.
package flow_pkg;

   localparam int WIDTH_DEFAULT   = 16;
   localparam int TIMEOUT_DEFAULT = 15;

   localparam logic [1:0] LOAD_SELF = 2'b00;
   localparam logic [1:0] LOAD_ALU  = 2'b01;
   localparam logic [1:0] LOAD_MEM  = 2'b10;
   localparam logic [1:0] LOAD_STK  = 2'b11;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'b00,
      WB_STORE = 2'b01,
      WB_LOAD  = 2'b10,
      WB_WRITE = 2'b11
   } wb_state_t;

   function automatic logic is_bus_load(input logic [1:0] src);
      return (src == LOAD_MEM) || (src == LOAD_STK);
   endfunction

endpackage

// File: rtl/bus_requester.sv
// One req/ack bus master: holds req/we/addr/wdata until ack, aborts after TIMEOUT cycles.
module bus_requester
   import flow_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             start_we,
   input  logic [WIDTH-1:0] start_addr,
   input  logic [WIDTH-1:0] start_wdata,
   input  logic             ack,
   output logic             req,
   output logic             we,
   output logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] wdata,
   output logic             ack_seen,
   output logic             timed_out
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   logic             req_r;
   logic             we_r;
   logic [WIDTH-1:0] addr_r;
   logic [WIDTH-1:0] wdata_r;
   logic [CW-1:0]    wait_cnt_r;

   // An ack arriving in the final allowed cycle completes the access rather than aborting it.
   assign ack_seen  = req_r & ack;
   assign timed_out = req_r & ~ack & (wait_cnt_r == LAST_WAIT);

   // Request registers and wait counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
         wait_cnt_r <= '0;
      end else if (start) begin
         req_r      <= 1'b1;
         we_r       <= start_we;
         addr_r     <= start_addr;
         wdata_r    <= start_wdata;
         wait_cnt_r <= '0;
      end else if (ack_seen || timed_out) begin
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         wait_cnt_r <= '0;
      end else if (req_r) begin
         wait_cnt_r <= wait_cnt_r + 1'b1;
      end
   end

   assign req   = req_r;
   assign we    = we_r;
   assign addr  = addr_r;
   assign wdata = wdata_r;

endmodule

// File: rtl/alu_writeback_unit.sv
// Executes per-instruction writeback and store commands, sequencing mem/stk bus accesses
// and the register file write port; busy holds the PC while a command is in flight.
module alu_writeback_unit
   import flow_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             issue_valid,
   input  logic [3:0]       alu_out_select,
   input  logic [1:0]       alu_load_src,
   input  logic             alu_store_to_mem,
   input  logic             alu_store_to_stk,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] store_data,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             stk_req,
   output logic             stk_we,
   output logic [WIDTH-1:0] stk_addr,
   output logic [WIDTH-1:0] stk_wdata,
   input  logic [WIDTH-1:0] stk_rdata,
   input  logic             stk_ack,
   output logic             reg_we,
   output logic [3:0]       reg_waddr,
   output logic [WIDTH-1:0] reg_wdata
);

   wb_state_t        state_r, state_n;
   logic [3:0]       sel_r;
   logic [1:0]       src_r;
   logic             smem_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] sdata_r;

   logic             busy_r, done_r, error_r, reg_we_r;
   logic [3:0]       waddr_r;
   logic [WIDTH-1:0] wdata_r;
   logic             done_n, error_n, reg_we_n;
   logic [3:0]       waddr_n;
   logic [WIDTH-1:0] wdata_n;

   logic             accept_s;
   logic             start_mem_s, start_stk_s, start_we_s;
   logic [WIDTH-1:0] start_addr_s, start_wdata_s;
   logic             mem_ack_seen_s, mem_timed_out_s, stk_ack_seen_s, stk_timed_out_s;
   logic             store_ack_s, store_to_s;
   logic             load_on_mem_s, load_req_s, load_ack_s, load_to_s;
   logic [WIDTH-1:0] load_rdata_s;

   assign accept_s = issue_valid & ~busy_r;

   // Route the active bus status to the FSM for the store and load phases.
   always_comb begin
      store_ack_s   = smem_r ? mem_ack_seen_s  : stk_ack_seen_s;
      store_to_s    = smem_r ? mem_timed_out_s : stk_timed_out_s;
      load_on_mem_s = (src_r == LOAD_MEM);
      load_req_s    = load_on_mem_s ? mem_req         : stk_req;
      load_ack_s    = load_on_mem_s ? mem_ack_seen_s  : stk_ack_seen_s;
      load_to_s     = load_on_mem_s ? mem_timed_out_s : stk_timed_out_s;
      load_rdata_s  = load_on_mem_s ? mem_rdata       : stk_rdata;
      if (state_r == WB_IDLE) begin
         start_addr_s  = alu_result;
         start_wdata_s = store_data;
      end else begin
         start_addr_s  = result_r;
         start_wdata_s = sdata_r;
      end
   end

   // Next state, bus launches and next values of the registered outputs.
   always_comb begin
      state_n     = state_r;
      done_n      = 1'b0;
      error_n     = 1'b0;
      reg_we_n    = 1'b0;
      waddr_n     = waddr_r;
      wdata_n     = wdata_r;
      start_mem_s = 1'b0;
      start_stk_s = 1'b0;
      start_we_s  = 1'b0;
      case (state_r)
         WB_IDLE: begin
            if (!accept_s) begin
               state_n = WB_IDLE;
            end else if (alu_store_to_mem && alu_store_to_stk) begin
               state_n = WB_WRITE;
               done_n  = 1'b1;
               error_n = 1'b1;
            end else if (alu_store_to_mem || alu_store_to_stk) begin
               state_n     = WB_STORE;
               start_mem_s = alu_store_to_mem;
               start_stk_s = alu_store_to_stk;
               start_we_s  = 1'b1;
            end else if (is_bus_load(alu_load_src)) begin
               state_n     = WB_LOAD;
               start_mem_s = (alu_load_src == LOAD_MEM);
               start_stk_s = (alu_load_src == LOAD_STK);
            end else begin
               state_n = WB_WRITE;
               done_n  = 1'b1;
               if (alu_load_src == LOAD_ALU) begin
                  reg_we_n = 1'b1;
                  waddr_n  = alu_out_select;
                  wdata_n  = alu_result;
               end else begin
                  reg_we_n = 1'b0;
               end
            end
         end
         WB_STORE: begin
            if (store_ack_s) begin
               if (is_bus_load(src_r)) begin
                  // Read-after-write leaves one idle bus cycle before the read request.
                  state_n = WB_LOAD;
               end else begin
                  state_n = WB_WRITE;
                  done_n  = 1'b1;
                  if (src_r == LOAD_ALU) begin
                     reg_we_n = 1'b1;
                     waddr_n  = sel_r;
                     wdata_n  = result_r;
                  end else begin
                     reg_we_n = 1'b0;
                  end
               end
            end else if (store_to_s) begin
               state_n = WB_WRITE;
               done_n  = 1'b1;
               error_n = 1'b1;
            end else begin
               state_n = WB_STORE;
            end
         end
         WB_LOAD: begin
            if (!load_req_s) begin
               start_mem_s = load_on_mem_s;
               start_stk_s = ~load_on_mem_s;
            end else if (load_ack_s) begin
               state_n  = WB_WRITE;
               done_n   = 1'b1;
               reg_we_n = 1'b1;
               waddr_n  = sel_r;
               wdata_n  = load_rdata_s;
            end else if (load_to_s) begin
               state_n = WB_WRITE;
               done_n  = 1'b1;
               error_n = 1'b1;
            end else begin
               state_n = WB_LOAD;
            end
         end
         WB_WRITE: state_n = WB_IDLE;
         default:  state_n = WB_IDLE;
      endcase
   end

   // State, captured command and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r  <= WB_IDLE;
         sel_r    <= 4'h0;
         src_r    <= LOAD_SELF;
         smem_r   <= 1'b0;
         result_r <= '0;
         sdata_r  <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         reg_we_r <= 1'b0;
         waddr_r  <= 4'h0;
         wdata_r  <= '0;
      end else begin
         state_r  <= state_n;
         busy_r   <= (state_n != WB_IDLE);
         done_r   <= done_n;
         error_r  <= error_n;
         reg_we_r <= reg_we_n;
         waddr_r  <= waddr_n;
         wdata_r  <= wdata_n;
         if (accept_s) begin
            sel_r    <= alu_out_select;
            src_r    <= alu_load_src;
            smem_r   <= alu_store_to_mem;
            result_r <= alu_result;
            sdata_r  <= store_data;
         end
      end
   end

   bus_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_mem_bus (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start_mem_s),
      .start_we    (start_we_s),
      .start_addr  (start_addr_s),
      .start_wdata (start_wdata_s),
      .ack         (mem_ack),
      .req         (mem_req),
      .we          (mem_we),
      .addr        (mem_addr),
      .wdata       (mem_wdata),
      .ack_seen    (mem_ack_seen_s),
      .timed_out   (mem_timed_out_s)
   );

   bus_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_stk_bus (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start_stk_s),
      .start_we    (start_we_s),
      .start_addr  (start_addr_s),
      .start_wdata (start_wdata_s),
      .ack         (stk_ack),
      .req         (stk_req),
      .we          (stk_we),
      .addr        (stk_addr),
      .wdata       (stk_wdata),
      .ack_seen    (stk_ack_seen_s),
      .timed_out   (stk_timed_out_s)
   );

   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign reg_we    = reg_we_r;
   assign reg_waddr = waddr_r;
   assign reg_wdata = wdata_r;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Self-checking bench: a phase-level model predicts the per-cycle bus/writeback trace of each command.
module tb_alu_writeback_unit;

   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 15;
   localparam int NEVER   = 1000;

   logic        clock, resetn, issue_valid;
   logic [3:0]  alu_out_select;
   logic [1:0]  alu_load_src;
   logic        alu_store_to_mem, alu_store_to_stk;
   logic [15:0] alu_result, store_data;
   logic        busy, done, error;
   logic        mem_req, mem_we, mem_ack, stk_req, stk_we, stk_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, stk_addr, stk_wdata, stk_rdata;
   logic        reg_we;
   logic [3:0]  reg_waddr;
   logic [15:0] reg_wdata;

   typedef struct packed {
      logic        mreq, mwe;
      logic [15:0] maddr, mwdata;
      logic        sreq, swe;
      logic [15:0] saddr, swdata;
      logic        rwe;
      logic [3:0]  waddr;
      logic [15:0] wdata;
      logic        done, err, busy;
   } obs_t;

   obs_t        exp_q[$];
   obs_t        obs_q[$];
   logic [1:0]  ack_q[$];
   int          tests, fails;
   logic [3:0]  last_waddr;
   logic [15:0] last_wdata;

   alu_writeback_unit #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .resetn(resetn), .issue_valid(issue_valid),
      .alu_out_select(alu_out_select), .alu_load_src(alu_load_src),
      .alu_store_to_mem(alu_store_to_mem), .alu_store_to_stk(alu_store_to_stk),
      .alu_result(alu_result), .store_data(store_data),
      .busy(busy), .done(done), .error(error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stk_req(stk_req), .stk_we(stk_we), .stk_addr(stk_addr), .stk_wdata(stk_wdata),
      .stk_rdata(stk_rdata), .stk_ack(stk_ack),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One bus phase: requests until ack after 'delay' cycles, or aborts after TIMEOUT cycles.
   task automatic add_phase(input bit on_mem, input bit we, input int delay,
                            input logic [15:0] addr, input logic [15:0] wd, output bit ok);
      obs_t e;
      int   n;
      ok = (delay < TIMEOUT);
      n  = ok ? delay + 1 : TIMEOUT;
      for (int i = 1; i <= n; i++) begin
         e = '0;
         e.busy  = 1'b1;
         e.waddr = last_waddr;
         e.wdata = last_wdata;
         if (on_mem) begin
            e.mreq = 1'b1; e.mwe = we; e.maddr = addr; e.mwdata = we ? wd : 16'h0000;
         end else begin
            e.sreq = 1'b1; e.swe = we; e.saddr = addr; e.swdata = we ? wd : 16'h0000;
         end
         exp_q.push_back(e);
         ack_q.push_back((ok && i == n) ? (on_mem ? 2'b10 : 2'b01) : 2'b00);
      end
   endtask

   // Builds the expected trace for one command, then drives it and records what the DUT shows.
   task automatic exec_cmd(input logic smem, input logic sstk, input logic [1:0] src,
                           input logic [3:0] sel, input logic [15:0] res, input logic [15:0] sd,
                           input int sdel, input int ldel, input logic [15:0] rdv, input bit noise);
      obs_t e, o;
      bit   ok, illegal, is_store, is_bus_load;
      exp_q.delete(); obs_q.delete(); ack_q.delete();
      illegal     = smem && sstk;
      is_store    = smem || sstk;
      is_bus_load = (src == 2'b10) || (src == 2'b11);
      ok = 1'b1;
      if (!illegal) begin
         if (is_store) add_phase(smem, 1'b1, sdel, res, sd, ok);
         if (ok && is_bus_load) begin
            if (is_store) begin
               e = '0; e.busy = 1'b1; e.waddr = last_waddr; e.wdata = last_wdata;
               exp_q.push_back(e); ack_q.push_back(2'b00);
            end
            add_phase(src == 2'b10, 1'b0, ldel, res, sd, ok);
         end
      end
      e = '0;
      e.busy = 1'b1; e.done = 1'b1;
      e.err  = illegal || !ok;
      e.rwe  = !illegal && ok && (src != 2'b00);
      if (e.rwe) begin
         last_waddr = sel;
         last_wdata = (src == 2'b01) ? res : rdv;
      end
      e.waddr = last_waddr; e.wdata = last_wdata;
      exp_q.push_back(e); ack_q.push_back(2'b00);
      e = '0; e.waddr = last_waddr; e.wdata = last_wdata;
      exp_q.push_back(e); ack_q.push_back(2'b00);

      issue_valid = 1'b1; alu_store_to_mem = smem; alu_store_to_stk = sstk;
      alu_load_src = src; alu_out_select = sel; alu_result = res; store_data = sd;
      mem_ack = 1'b0; stk_ack = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clock);
         o = '0;
         o.mreq = mem_req;
         if (mem_req) begin
            o.mwe = mem_we; o.maddr = mem_addr;
            if (mem_we) o.mwdata = mem_wdata;
         end
         o.sreq = stk_req;
         if (stk_req) begin
            o.swe = stk_we; o.saddr = stk_addr;
            if (stk_we) o.swdata = stk_wdata;
         end
         o.rwe = reg_we; o.waddr = reg_waddr; o.wdata = reg_wdata;
         o.done = done; o.err = error; o.busy = busy;
         obs_q.push_back(o);
         issue_valid      = noise && exp_q[k].busy && ($urandom_range(0, 1) == 1);
         alu_store_to_mem = 1'($urandom);
         alu_store_to_stk = 1'($urandom);
         alu_load_src     = 2'($urandom);
         alu_out_select   = 4'($urandom);
         alu_result       = 16'($urandom);
         store_data       = 16'($urandom);
         mem_ack   = ack_q[k][1];
         stk_ack   = ack_q[k][0];
         mem_rdata = mem_ack ? rdv : 16'($urandom);
         stk_rdata = stk_ack ? rdv : 16'($urandom);
         if (noise && !exp_q[k].mreq && !mem_ack) mem_ack = 1'($urandom);
         if (noise && !exp_q[k].sreq && !stk_ack) stk_ack = 1'($urandom);
      end
      issue_valid = 1'b0; mem_ack = 1'b0; stk_ack = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; issue_valid = 1'b0; mem_ack = 1'b0; stk_ack = 1'b0;
      alu_store_to_mem = 1'b0; alu_store_to_stk = 1'b0; alu_load_src = 2'b00;
      alu_out_select = 4'h0; alu_result = 16'h0000; store_data = 16'h0000;
      mem_rdata = 16'h0000; stk_rdata = 16'h0000;
      last_waddr = 4'h0; last_wdata = 16'h0000;
      repeat (2) @(negedge clock);
      tests++;
      if ({busy, done, error, mem_req, mem_we, stk_req, stk_we, reg_we} !== 8'h00 ||
          {mem_addr, mem_wdata, stk_addr, stk_wdata, reg_wdata} !== 80'h0 || reg_waddr !== 4'h0) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b err=%b mreq=%b sreq=%b rwe=%b waddr=%h wdata=%h, all required 0",
                  busy, done, error, mem_req, stk_req, reg_we, reg_waddr, reg_wdata);
      end
      resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_alu_write();
      exec_cmd(1'b0, 1'b0, 2'b01, 4'd5, 16'h1234, 16'h0000, 0, 0, 16'h0000, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL alu_write cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
      tests++;
      if (obs_q[0].rwe !== 1'b1 || obs_q[0].waddr !== 4'd5 || obs_q[0].wdata !== 16'h1234) begin
         fails++; $display("FAIL alu_latency: got we=%b addr=%h data=%h, required 1/5/1234",
                           obs_q[0].rwe, obs_q[0].waddr, obs_q[0].wdata);
      end
   endtask

   task automatic test_store_mem();
      int reqs;
      exec_cmd(1'b1, 1'b0, 2'b00, 4'd9, 16'h0040, 16'hBEEF, 3, 0, 16'h0000, 1'b0);
      reqs = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k].mreq) reqs++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL store_mem cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
      tests++;
      if (reqs !== 4) begin
         fails++; $display("FAIL store_mem_req_len: got %0d cycles, required 4", reqs);
      end
   endtask

   task automatic test_load_stk();
      int busy_cycles, mreqs;
      exec_cmd(1'b0, 1'b0, 2'b11, 4'd2, 16'h0003, 16'h0000, 0, 1, 16'h00AA, 1'b0);
      busy_cycles = 0; mreqs = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k].busy) busy_cycles++;
         if (obs_q[k].mreq) mreqs++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL load_stk cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
      tests++;
      if (busy_cycles !== 3 || mreqs !== 0 || last_wdata !== 16'h00AA) begin
         fails++; $display("FAIL load_stk_summary: busy=%0d mem_req=%0d, required 3 and 0", busy_cycles, mreqs);
      end
   endtask

   task automatic test_illegal();
      exec_cmd(1'b1, 1'b1, 2'b01, 4'd4, 16'h5555, 16'hAAAA, 0, 0, 16'h0000, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL illegal cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_timeout();
      exec_cmd(1'b0, 1'b0, 2'b10, 4'd6, 16'h0777, 16'h0000, 0, NEVER, 16'h0000, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL timeout cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
      // Ack in the last allowed cycle completes the load.
      exec_cmd(1'b0, 1'b0, 2'b10, 4'd7, 16'h0778, 16'h0000, 0, TIMEOUT - 1, 16'h3C3C, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL ack_on_last cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      exec_cmd(1'b1, 1'b0, 2'b10, 4'd3, 16'h0100, 16'hCAFE, 1, 2, 16'hCAFE, 1'b1);
      for (int k = 0; k < exp_q.size(); k++) begin
         tests++;
         if (obs_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL store_then_load cycle %0d: got %h, required %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_reset_in_load();
      issue_valid = 1'b1; alu_store_to_mem = 1'b0; alu_store_to_stk = 1'b0;
      alu_load_src = 2'b10; alu_out_select = 4'd8; alu_result = 16'h0100;
      @(negedge clock);
      issue_valid = 1'b0;
      repeat (2) @(negedge clock);
      tests++;
      if (mem_req !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL pre_reset_load: mem_req=%b busy=%b, required 1/1", mem_req, busy);
      end
      #2 resetn = 1'b0;
      #1;
      tests++;
      if ({mem_req, stk_req, busy, reg_we, done, error} !== 6'b0) begin
         fails++; $display("FAIL reset_in_load: req=%b busy=%b reg_we=%b, required 0", mem_req, busy, reg_we);
      end
      @(negedge clock);
      resetn = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clock);
      mem_ack = 1'b0;
      last_waddr = 4'h0; last_wdata = 16'h0000;
      tests++;
      if ({mem_req, stk_req, busy, reg_we, done, error} !== 6'b0 || reg_waddr !== last_waddr ||
          reg_wdata !== last_wdata) begin
         fails++; $display("FAIL stray_ack: req=%b busy=%b reg_we=%b wdata=%h, required idle and 0",
                           mem_req, busy, reg_we, reg_wdata);
      end
   endtask

   task automatic test_random();
      logic        smem, sstk;
      logic [1:0]  src;
      int          sdel, ldel;
      for (int i = 0; i < 30; i++) begin
         smem = ($urandom_range(0, 2) == 0);
         sstk = ($urandom_range(0, 2) == 0);
         src  = 2'($urandom);
         sdel = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
         ldel = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
         exec_cmd(smem, sstk, src, 4'($urandom), 16'($urandom), 16'($urandom), sdel, ldel,
                  16'($urandom), $urandom_range(0, 1) == 1);
         for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
               fails++; $display("FAIL random cmd %0d cycle %0d: got %h, required %h", i, k, obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_alu_write();
      test_store_mem();
      test_load_stk();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_in_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
